// File: rtl/reg_writer_pkg.sv
// reg_writer_pkg: shared sizes and register index helper for the write-back block
package reg_writer_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_NUM   = 64;
    localparam int WB_DEPTH  = 4;
    localparam int NUM_W     = 5;
    localparam int IDX_W     = 6;

    function automatic logic [IDX_W-1:0] reg_idx(input logic gfflag, input logic [NUM_W-1:0] num);
        return {gfflag, num};
    endfunction
endpackage

// File: rtl/reg_writer_wb_fifo.sv
// wb_fifo: circular buffer holding long-latency write-backs in arrival order
module wb_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_push, do_pop;

    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign dout  = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // next-state: pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // state registers; reset empties the queue
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/reg_writer.sv
// reg_writer: architectural register file write-back with ALU priority, buffered long-latency port and busy scoreboard
module reg_writer
    import reg_writer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NUM   = DEF_NUM,
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 a_we,
    input  logic                 a_gfflag,
    input  logic [NUM_W-1:0]     a_num,
    input  logic [WIDTH-1:0]     a_data,
    input  logic                 l_valid,
    output logic                 l_ready,
    input  logic                 l_gfflag,
    input  logic [NUM_W-1:0]     l_num,
    input  logic [WIDTH-1:0]     l_data,
    input  logic                 set_valid,
    input  logic                 set_gfflag,
    input  logic [NUM_W-1:0]     set_num,
    output logic [WIDTH*NUM-1:0] regsout,
    output logic [NUM-1:0]       busy
);
    localparam int EW = IDX_W + WIDTH;

    logic [NUM-1:0][WIDTH-1:0] regs_q, regs_d;
    logic [NUM-1:0] busy_q, busy_d;
    logic [EW-1:0] head;
    logic [IDX_W-1:0] a_idx, set_idx, head_idx, wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic empty, full, pop, wr_en;

    assign a_idx    = reg_idx(a_gfflag, a_num);
    assign set_idx  = reg_idx(set_gfflag, set_num);
    assign head_idx = head[EW-1 -: IDX_W];
    assign pop      = !a_we && !empty;
    assign l_ready  = !full;
    assign regsout  = regs_q;
    assign busy     = busy_q;

    wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (l_valid),
        .din   ({l_gfflag, l_num, l_data}),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .full  (full)
    );

    // arbitrate ALU over FIFO head, mask the zero register, and update the scoreboard (set beats clear)
    always_comb begin
        wr_en   = a_we || !empty;
        wr_idx  = a_we ? a_idx : head_idx;
        wr_data = a_we ? a_data : head[WIDTH-1:0];
        regs_d  = regs_q;
        if (wr_en && wr_idx != '0) regs_d[wr_idx] = wr_data;
        for (int i = 0; i < NUM; i++)
            busy_d[i] = (set_valid && set_idx == IDX_W'(i)) ? 1'b1 :
                        (wr_en && wr_idx == IDX_W'(i)) ? 1'b0 : busy_q[i];
        busy_d[0] = 1'b0;
    end

    // register file and scoreboard state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end
endmodule

// File: tb/tb_reg_writer.sv
// tb_reg_writer: directed and random checks of reg_writer against a queue-based model
module tb_reg_writer;
    localparam int W = 32;
    localparam int N = 64;
    localparam int D = 4;

    logic clk = 0;
    logic rstn = 0;
    logic a_we = 0, a_gfflag = 0, l_valid = 0, l_gfflag = 0, set_valid = 0, set_gfflag = 0;
    logic [4:0] a_num = 0, l_num = 0, set_num = 0;
    logic [W-1:0] a_data = 0, l_data = 0;
    logic l_ready;
    logic [W*N-1:0] regsout;
    logic [N-1:0] busy;

    int total = 0;
    int bad = 0;

    typedef struct { int idx; logic [W-1:0] data; } ent_t;
    ent_t mq[$];
    logic [W-1:0] mr [N];
    logic mb [N];

    reg_writer dut (
        .clk(clk), .rstn(rstn),
        .a_we(a_we), .a_gfflag(a_gfflag), .a_num(a_num), .a_data(a_data),
        .l_valid(l_valid), .l_ready(l_ready), .l_gfflag(l_gfflag), .l_num(l_num), .l_data(l_data),
        .set_valid(set_valid), .set_gfflag(set_gfflag), .set_num(set_num),
        .regsout(regsout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rd(input int i);
        return regsout[i*W +: W];
    endfunction

    task automatic model_clear();
        mq.delete();
        for (int i = 0; i < N; i++) begin
            mr[i] = '0;
            mb[i] = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        a_we = 0; l_valid = 0; set_valid = 0;
        a_gfflag = 0; l_gfflag = 0; set_gfflag = 0;
        a_num = 0; l_num = 0; set_num = 0; a_data = 0; l_data = 0;
    endtask

    // advance the model by one edge from the currently driven inputs, then clock the DUT
    task automatic step();
        int wi;
        logic [W-1:0] wd;
        logic do_push;
        ent_t e;
        do_push = l_valid && (mq.size() < D);
        wi = -1;
        wd = '0;
        if (a_we) begin
            wi = {a_gfflag, a_num};
            wd = a_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            wi = e.idx;
            wd = e.data;
        end
        if (wi > 0) mr[wi] = wd;
        if (wi >= 0) mb[wi] = 1'b0;
        if (set_valid && {set_gfflag, set_num} != 6'd0) mb[{set_gfflag, set_num}] = 1'b1;
        if (do_push) begin
            e.idx = {l_gfflag, l_num};
            e.data = l_data;
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 0;
        idle_inputs();
        model_clear();
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        step();
        total++; if (regsout !== '0) begin bad++; $display("FAIL reset_regs nonzero regsout"); end
        total++; if (busy !== '0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
        total++; if (l_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", l_ready); end
    endtask

    task automatic test_alu();
        a_we = 1; a_gfflag = 0; a_num = 5; a_data = 32'h0000_1234;
        step();
        a_we = 0;
        total++; if (rd(5) !== 32'h1234) begin bad++; $display("FAIL alu_reg5 got=%h exp=%h", rd(5), 32'h1234); end
        a_we = 1; a_gfflag = 1;
        step();
        a_we = 0;
        total++; if (rd(37) !== 32'h1234) begin bad++; $display("FAIL alu_reg37 got=%h exp=%h", rd(37), 32'h1234); end
        total++; if (rd(5) !== 32'h1234) begin bad++; $display("FAIL alu_reg5_kept got=%h exp=%h", rd(5), 32'h1234); end
    endtask

    task automatic test_zero();
        a_we = 1; a_gfflag = 0; a_num = 0; a_data = 32'hFFFF_FFFF;
        step();
        a_we = 0;
        total++; if (rd(0) !== 32'h0) begin bad++; $display("FAIL zero_reg0 got=%h exp=0", rd(0)); end
        set_valid = 1; set_gfflag = 0; set_num = 0;
        step();
        set_valid = 0;
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL zero_busy0 got=%b exp=0", busy[0]); end
        a_we = 1; a_gfflag = 1; a_num = 0; a_data = 32'hFFFF_FFFF;
        step();
        a_we = 0;
        total++; if (rd(32) !== 32'hFFFF_FFFF) begin bad++; $display("FAIL zero_reg32 got=%h exp=ffffffff", rd(32)); end
    endtask

    task automatic test_arbitration();
        a_we = 1; a_gfflag = 0; a_num = 4; a_data = 32'h100;
        l_valid = 1; l_gfflag = 0; l_num = 3; l_data = 32'hAA;
        step();
        l_valid = 0;
        total++; if (rd(4) !== 32'h100) begin bad++; $display("FAIL arb_reg4_0 got=%h exp=100", rd(4)); end
        for (int k = 1; k < 3; k++) begin
            a_data = 32'h100 + k;
            step();
            total++; if (rd(4) !== 32'h100 + k) begin bad++; $display("FAIL arb_reg4_%0d got=%h exp=%h", k, rd(4), 32'h100 + k); end
            total++; if (rd(3) !== 32'h0) begin bad++; $display("FAIL arb_reg3_stall%0d got=%h exp=0", k, rd(3)); end
        end
        a_we = 0;
        step();
        total++; if (rd(3) !== 32'hAA) begin bad++; $display("FAIL arb_reg3_commit got=%h exp=aa", rd(3)); end
    endtask

    task automatic test_fifo_full();
        int nums [5] = '{1, 2, 3, 4, 6};
        a_we = 1; a_gfflag = 0; a_num = 10; a_data = 32'h55;
        for (int k = 0; k < 5; k++) begin
            l_valid = 1; l_gfflag = 0; l_num = 5'(nums[k]); l_data = 32'(k + 1);
            #0;
            total++; if (l_ready !== (k < 4)) begin bad++; $display("FAIL full_ready%0d got=%b exp=%b", k, l_ready, k < 4); end
            if (k < 4) step();
        end
        step();
        total++; if (l_ready !== 1'b0) begin bad++; $display("FAIL full_held got=%b exp=0", l_ready); end
        a_we = 0;
        step();
        total++; if (rd(1) !== 32'd1) begin bad++; $display("FAIL full_reg1 got=%h exp=1", rd(1)); end
        total++; if (l_ready !== 1'b1) begin bad++; $display("FAIL full_ready_back got=%b exp=1", l_ready); end
        step();
        l_valid = 0;
        total++; if (rd(2) !== 32'd2) begin bad++; $display("FAIL full_reg2 got=%h exp=2", rd(2)); end
        step();
        total++; if (rd(3) !== 32'd3) begin bad++; $display("FAIL full_reg3 got=%h exp=3", rd(3)); end
        step();
        total++; if (rd(4) !== 32'd4) begin bad++; $display("FAIL full_reg4 got=%h exp=4", rd(4)); end
        total++; if (rd(6) !== 32'd0) begin bad++; $display("FAIL full_reg6_early got=%h exp=0", rd(6)); end
        step();
        total++; if (rd(6) !== 32'd5) begin bad++; $display("FAIL full_reg6 got=%h exp=5", rd(6)); end
    endtask

    task automatic test_scoreboard();
        set_valid = 1; set_gfflag = 1; set_num = 7;
        step();
        set_valid = 0;
        total++; if (busy[39] !== 1'b1) begin bad++; $display("FAIL sb_set39 got=%b exp=1", busy[39]); end
        l_valid = 1; l_gfflag = 1; l_num = 7; l_data = 32'h77;
        step();
        l_valid = 0;
        total++; if (busy[39] !== 1'b1) begin bad++; $display("FAIL sb_hold39 got=%b exp=1", busy[39]); end
        step();
        total++; if (busy[39] !== 1'b0) begin bad++; $display("FAIL sb_clr39 got=%b exp=0", busy[39]); end
        total++; if (rd(39) !== 32'h77) begin bad++; $display("FAIL sb_reg39 got=%h exp=77", rd(39)); end
        set_valid = 1; set_gfflag = 0; set_num = 9;
        a_we = 1; a_gfflag = 0; a_num = 9; a_data = 32'h99;
        step();
        set_valid = 0; a_we = 0;
        total++; if (busy[9] !== 1'b1) begin bad++; $display("FAIL sb_setwins9 got=%b exp=1", busy[9]); end
        total++; if (rd(9) !== 32'h99) begin bad++; $display("FAIL sb_reg9 got=%h exp=99", rd(9)); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            a_we = ($urandom_range(0, 9) < 4); a_gfflag = 1'($urandom); a_num = 5'($urandom); a_data = $urandom;
            l_valid = ($urandom_range(0, 1) == 1); l_gfflag = 1'($urandom); l_num = 5'($urandom); l_data = $urandom;
            set_valid = ($urandom_range(0, 9) < 3); set_gfflag = 1'($urandom); set_num = 5'($urandom);
            #0;
            total++; if (l_ready !== (mq.size() < D)) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, l_ready, mq.size() < D); end
            step();
            for (int i = 0; i < N; i++) begin
                total++; if (rd(i) !== mr[i]) begin bad++; $display("FAIL rnd_reg%0d c=%0d got=%h exp=%h", i, c, rd(i), mr[i]); end
                total++; if (busy[i] !== mb[i]) begin bad++; $display("FAIL rnd_busy%0d c=%0d got=%b exp=%b", i, c, busy[i], mb[i]); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        a_we = 1; a_gfflag = 0; a_num = 12; a_data = 32'hC0DE;
        set_valid = 1; set_gfflag = 1; set_num = 20;
        l_valid = 1; l_gfflag = 0; l_num = 13; l_data = 32'hBEEF;
        step();
        step();
        idle_inputs();
        #2 rstn = 0;
        #1;
        model_clear();
        total++; if (regsout !== '0) begin bad++; $display("FAIL mid_reset_regs nonzero regsout"); end
        total++; if (busy !== '0) begin bad++; $display("FAIL mid_reset_busy got=%h exp=0", busy); end
        total++; if (l_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready got=%b exp=1", l_ready); end
        @(posedge clk);
        #1 rstn = 1;
        step();
        step();
        total++; if (rd(13) !== 32'h0) begin bad++; $display("FAIL mid_reset_flushed got=%h exp=0", rd(13)); end
        total++; if (regsout !== '0) begin bad++; $display("FAIL mid_reset_idle nonzero regsout"); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_zero();
        test_arbitration();
        test_fifo_full();
        test_scoreboard();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
